// File: rtl/atm_session_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : atm_pkg
// Brief  : State encoding, operation codes and error codes for the ATM session.
// Rev    : 1.0
// ============================================================================
package atm_pkg;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_PIN    = 3'd1;
    localparam logic [2:0] c_ST_MENU   = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_EJECT  = 3'd4;
    localparam logic [2:0] c_ST_LOCKED = 3'd5;

    localparam logic [1:0] c_OP_BAL  = 2'b00;
    localparam logic [1:0] c_OP_WDR  = 2'b01;
    localparam logic [1:0] c_OP_DEP  = 2'b10;
    localparam logic [1:0] c_OP_EXIT = 2'b11;

    localparam logic [1:0] c_ERR_OK    = 2'b00;
    localparam logic [1:0] c_ERR_INSUF = 2'b01;
    localparam logic [1:0] c_ERR_OVF   = 2'b10;
    localparam logic [1:0] c_ERR_TMO   = 2'b11;

endpackage
`default_nettype wire

// File: rtl/atm_session_ctrl_watchdog.sv
`default_nettype none
// ============================================================================
// Module : session_watchdog
// Brief  : Saturating idle counter; pulses timeout on the last idle cycle.
// Rev    : 1.0
// ============================================================================
module session_watchdog #(
    parameter int IDLE_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_timeout
);

    localparam int              c_CW   = $clog2(IDLE_CYCLES + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(IDLE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_SAT  = c_CW'(IDLE_CYCLES);

    logic [c_CW-1:0] r_count;

    // Disabled means cleared, so every entry into an enabled state starts at zero.
    always_ff @(posedge clk) begin
        if (!rst || !i_en || i_clr) begin
            r_count <= '0;
        end else if (r_count != c_SAT) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_timeout = i_en && !i_clr && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/atm_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module : atm_session_ctrl
// Brief  : ATM session sequencer: card, PIN retry, menu, transaction, eject/retain.
// Rev    : 1.0
// ============================================================================
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int PIN_W       = 16,
    parameter int AMT_W       = 16,
    parameter int MAX_TRIES   = 3,
    parameter int IDLE_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             card_in,
    input  logic [PIN_W-1:0] card_pin,
    input  logic             key_valid,
    input  logic [PIN_W-1:0] key_pin,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    input  logic [AMT_W-1:0] op_amount,
    input  logic [AMT_W-1:0] balance_in,
    output logic             acct_we,
    output logic [AMT_W-1:0] balance_out,
    output logic             done,
    output logic [1:0]       err,
    output logic             eject,
    output logic             card_lock,
    output logic [2:0]       state_o
);

    localparam int              c_TW    = $clog2(MAX_TRIES + 1);
    localparam logic [c_TW-1:0] c_MAX_T = c_TW'(MAX_TRIES);

    logic [2:0]       r_state;
    logic [c_TW-1:0]  r_tries;
    logic             r_acct_we;
    logic [AMT_W-1:0] r_balance_out;
    logic             r_done;
    logic [1:0]       r_err;
    logic             r_eject;
    logic             r_card_lock;

    logic             w_wd_en;
    logic             w_wd_clr;
    logic             w_timeout;
    logic [c_TW-1:0]  w_tries_inc;
    logic [AMT_W:0]   w_sum;

    assign w_wd_en     = (r_state == c_ST_PIN) || (r_state == c_ST_MENU);
    assign w_wd_clr    = ((r_state == c_ST_PIN) && key_valid) || ((r_state == c_ST_MENU) && op_valid);
    assign w_tries_inc = r_tries + 1'b1;
    assign w_sum       = {1'b0, balance_in} + {1'b0, op_amount};

    session_watchdog #(
        .IDLE_CYCLES (IDLE_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_wd_en),
        .i_clr     (w_wd_clr),
        .o_timeout (w_timeout)
    );

    // The transaction result is computed on the accepting MENU edge so done/acct_we
    // are registered and visible during the single EXEC cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= c_ST_IDLE;
            r_tries       <= '0;
            r_acct_we     <= 1'b0;
            r_balance_out <= '0;
            r_done        <= 1'b0;
            r_err         <= c_ERR_OK;
            r_eject       <= 1'b0;
            r_card_lock   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_acct_we <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (card_in) begin
                        r_state <= c_ST_PIN;
                        r_tries <= '0;
                    end
                end
                c_ST_PIN: begin
                    if (!card_in) begin
                        r_state <= c_ST_IDLE;
                    end else if (key_valid) begin
                        if (key_pin == card_pin) begin
                            r_state <= c_ST_MENU;
                        end else if (w_tries_inc == c_MAX_T) begin
                            r_state     <= c_ST_LOCKED;
                            r_tries     <= w_tries_inc;
                            r_card_lock <= 1'b1;
                        end else begin
                            r_tries <= w_tries_inc;
                        end
                    end else if (w_timeout) begin
                        r_state <= c_ST_EJECT;
                        r_eject <= 1'b1;
                        r_err   <= c_ERR_TMO;
                    end
                end
                c_ST_MENU: begin
                    if (!card_in) begin
                        r_state <= c_ST_IDLE;
                    end else if (op_valid) begin
                        if (op_code == c_OP_EXIT) begin
                            r_state <= c_ST_EJECT;
                            r_eject <= 1'b1;
                            r_err   <= c_ERR_OK;
                        end else begin
                            r_state       <= c_ST_EXEC;
                            r_done        <= 1'b1;
                            r_balance_out <= balance_in;
                            r_err         <= c_ERR_OK;
                            case (op_code)
                                c_OP_WDR: begin
                                    if (op_amount <= balance_in) begin
                                        r_acct_we     <= 1'b1;
                                        r_balance_out <= balance_in - op_amount;
                                    end else begin
                                        r_err <= c_ERR_INSUF;
                                    end
                                end
                                c_OP_DEP: begin
                                    if (!w_sum[AMT_W]) begin
                                        r_acct_we     <= 1'b1;
                                        r_balance_out <= w_sum[AMT_W-1:0];
                                    end else begin
                                        r_err <= c_ERR_OVF;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end else if (w_timeout) begin
                        r_state <= c_ST_EJECT;
                        r_eject <= 1'b1;
                        r_err   <= c_ERR_TMO;
                    end
                end
                c_ST_EXEC: begin
                    r_state <= c_ST_MENU;
                    r_err   <= c_ERR_OK;
                end
                c_ST_EJECT: begin
                    if (!card_in) begin
                        r_state <= c_ST_IDLE;
                        r_eject <= 1'b0;
                        r_err   <= c_ERR_OK;
                    end
                end
                c_ST_LOCKED: ;
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign acct_we     = r_acct_we;
    assign balance_out = r_balance_out;
    assign done        = r_done;
    assign err         = r_err;
    assign eject       = r_eject;
    assign card_lock   = r_card_lock;
    assign state_o     = r_state;

endmodule
`default_nettype wire
